// File: rtl/nibble_tx.sv
// Serial transmitter for one 4-bit word per frame: start bit, 4 data bits LSB first, stop bit.
// Bit timing comes from a free cycle counter on the system clock; every output is registered.
module nibble_tx #(
    parameter int BIT_PERIOD = 434,
    parameter int CNT_W      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Data_in,
    input  logic       send,
    output logic       tx_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    // Handshake: send is a level request sampled only while IDLE; it is accepted on any
    // IDLE edge where send==1 (including the done cycle) and ignored while busy==1.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_bit_idx;
    logic [3:0]       r_shift;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;

    logic             w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (send) begin
                        r_shift <= Data_in;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx != 2'd3) begin
                            // shift[1] is the bit that becomes shift[0] after this edge
                            r_shift   <= {1'b0, r_shift[3:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 2'd1;
                        end else begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    // unused encodings fall back to a quiet line
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out    = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: doc/nibble_tx.md
Name: nibble_tx

Overview:
- Serial transmitter for a 4-bit word; it is the sending end of the switch-to-LED data path.
- It captures Data_in on a request and shifts it out on a single wire as one frame: start bit, 4 data bits LSB first, stop bit.
- Bit timing comes from an internal cycle counter driven by the board clock. No derived clock is used.
- Provides busy/done status for a controller or a pushbutton-driven requester.

Parameters:
- BIT_PERIOD, 434, clock cycles per serial bit (434 = 115200 baud at 50 MHz); legal range 2..65535.
- CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > BIT_PERIOD.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Data_in  in  4  word to transmit; sampled only when a request is accepted.
- send  in  1  transmit request; level-sampled in IDLE only.
- tx_out  out  1  serial line; idle/mark level is 1.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse after a frame completes.

Behaviour:
- Reset (reset==1 at a rising edge) takes effect on that edge and overrides all other inputs:
  - state=IDLE, tx_out=1, busy=0, done=0, bit counter=0, bit index=0, shift register=0.
  - Reset mid-frame aborts the frame; tx_out returns to 1 on the same edge; no done pulse.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: tx_out=1, busy=0.
    - If send==1, latch Data_in into the shift register and go to START.
    - On that edge: tx_out<=0, busy<=1, counter<=0.
  - START: hold tx_out=0 for BIT_PERIOD cycles.
    - On the edge where counter==BIT_PERIOD-1: go to DATA, tx_out<=shift[0], bit index<=0, counter<=0.
  - DATA: hold the current bit for BIT_PERIOD cycles.
    - At counter==BIT_PERIOD-1 with bit index<3: shift right, tx_out<=next bit, index+1, counter<=0.
    - At counter==BIT_PERIOD-1 with index==3: go to STOP, tx_out<=1, counter<=0.
  - STOP: hold tx_out=1 for BIT_PERIOD cycles.
    - At counter==BIT_PERIOD-1: go to IDLE, busy<=0, done<=1.
- done is high for exactly one cycle, the first IDLE cycle after STOP; it is 0 in all other cycles.
- Latency and frame length:
  - send is sampled at edge E0; tx_out falls on E0.
  - The frame occupies exactly 6*BIT_PERIOD cycles of busy=1.
  - done=1 in the cycle immediately after busy falls.
- Back-to-back frames:
  - send is honoured in any IDLE cycle, including the cycle where done=1.
  - With send held high continuously, frames repeat with an idle gap of exactly 1 cycle: tx_out=1 for BIT_PERIOD+1 cycles between frames.
- While busy: send is ignored (no queueing, no error), and changes on Data_in do not affect the frame in flight.
- Counter rules:
  - The counter counts 0..BIT_PERIOD-1 and wraps to 0 at every bit boundary.
  - The counter holds 0 in IDLE.
  - No arithmetic overflow is possible given the CNT_W constraint.
- Illegal states (unused encodings) recover to IDLE with tx_out=1 on the next edge.

Test Plan:
1. Reset check: assert reset 3 cycles with send=1 -> tx_out=1, busy=0, done=0 throughout and 1 cycle after release. No frame starts until the first post-reset edge with send=1.
2. Single frame (BIT_PERIOD=4): Data_in=4'b1010, 1-cycle send pulse at E0 -> tx_out over 24 cycles = 0000 0000 1111 0000 1111 1111 (start, d0=0, d1=1, d2=0, d3=1, stop). busy=1 for those 24 cycles, then done=1 for 1 cycle, then tx_out=1, busy=0.
3. Data stability (BIT_PERIOD=4): send with Data_in=4'hF, then change Data_in to 4'h0 and pulse send again at cycle 10 -> frame still carries 1111 and the second send is ignored. Exactly one done pulse.
4. Continuous send (BIT_PERIOD=4): hold send=1, Data_in=4'h3 -> frames repeat every 25 cycles with tx_out bits 0,1,1,0,0,1. Each inter-frame high time is 5 cycles; done pulses at the 25-cycle period.
5. Reset mid-frame (BIT_PERIOD=4): start a frame with 4'h0, assert reset at cycle 9 -> tx_out=1, busy=0 on that edge, and no done pulse. A new send after release produces a complete, correct frame.
6. Timing at default BIT_PERIOD=434: one frame of 4'h5 -> busy high for exactly 2604 cycles; each bit boundary falls on a multiple of 434 cycles from the start edge.
